systolic_seq_ctrl: RTL

Sequencer for a DIM x DIM weight-less systolic MAC array built from the team's PE tile. It is started by the host with an inner dimension K. It then:
- drives the array-wide start_operation,
- generates the skewed per-row and per-column operand read enables and indices,
- times the drain,
- holds results stable until acknowledged,
- clears the array by dropping start_operation for at least one cycle.

It sits between the host/CSR interface and the array plus operand register files.

---
 rtl/systolic_seq_ctrl_pkg.sv | 16 +
 rtl/systolic_seq_ctrl_skew_gen.sv | 23 ++
 rtl/systolic_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  // Cycles from the first operand beat until the last PE has consumed its last product.
  function automatic int unsigned total_cycles(input int unsigned k, input int unsigned dim);
    return k + 2 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_gen.sv
// Per-lane operand skew: lane i is live for i <= t < K+i and reads index t-i.
module systolic_skew_gen #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned K_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH = 12
) (
  input  logic [CNT_WIDTH-1:0]     t,
  input  logic [K_WIDTH-1:0]       k_len,
  output logic [DIM-1:0]           lane_en_c,
  output logic [DIM*K_WIDTH-1:0]   lane_idx_c
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic                 started;
    logic [CNT_WIDTH-1:0] rel;

    assign started      = (t >= CNT_WIDTH'(i));
    assign rel          = t - CNT_WIDTH'(i);
    assign lane_en_c[i] = started && (rel < CNT_WIDTH'(k_len));
    assign lane_idx_c[i*K_WIDTH +: K_WIDTH] = lane_en_c[i] ? rel[K_WIDTH-1:0] : '0;
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: feed, drain, hold, clear.
// Optional cycle counter on perf_cycles_o built when SYSTOLIC_SEQ_CTRL_PERF_EN is defined.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int unsigned DIM     = 4,
  parameter int unsigned K_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [K_WIDTH-1:0]       k_len_i,
  input  logic                     result_ack_i,
  input  logic [DIM*DIM-1:0]       ov_flags_i,
  output logic                     pe_start_o,
  output logic [DIM-1:0]           lane_en_o,
  output logic [DIM*K_WIDTH-1:0]   lane_idx_o,
  output logic                     busy_o,
  output logic                     result_valid_o,
  output logic                     ov_any_o,
  output logic                     err_o,
  output logic [31:0]              perf_cycles_o
);

  localparam int unsigned CNT_WIDTH = K_WIDTH + $clog2(2 * DIM) + 1;

  seq_state_e             state_q;
  seq_state_e             state_d;
  logic [CNT_WIDTH-1:0]   t_q;
  logic [K_WIDTH-1:0]     k_q;
  logic [CNT_WIDTH-1:0]   feed_last;
  logic [CNT_WIDTH-1:0]   drain_last;
  logic                   accept;

  logic [DIM-1:0]         skew_en;
  logic [DIM*K_WIDTH-1:0] skew_idx;

  logic                   pe_start_d;
  logic [DIM-1:0]         lane_en_d;
  logic [DIM*K_WIDTH-1:0] lane_idx_d;
  logic                   busy_d;
  logic                   result_valid_d;
  logic                   ov_any_d;
  logic                   err_d;

  assign accept     = (state_q == IDLE) && start_i && (k_len_i != '0);
  assign feed_last  = CNT_WIDTH'(total_cycles(32'(k_q), DIM) - DIM);
  assign drain_last = CNT_WIDTH'(total_cycles(32'(k_q), DIM) - 32'd1);

  systolic_skew_gen #(
    .DIM       (DIM),
    .K_WIDTH   (K_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_skew (
    .t          (t_q),
    .k_len      (k_q),
    .lane_en_c  (skew_en),
    .lane_idx_c (skew_idx)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FEED;
      FEED:    if (t_q == feed_last) state_d = (DIM == 1) ? HOLD : DRAIN;
      DRAIN:   if (t_q == drain_last) state_d = HOLD;
      HOLD:    if (result_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched K and compute-cycle counter; t only advances while operands are in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      t_q <= '0;
      k_q <= k_len_i;
    end else if ((state_q == FEED) || (state_q == DRAIN)) begin
      t_q <= t_q + CNT_WIDTH'(1);
    end
  end

  // Output decode; an ack in HOLD releases the array on the same edge the FSM leaves
  always_comb begin
    pe_start_d     = 1'b0;
    lane_en_d      = '0;
    lane_idx_d     = '0;
    busy_d         = 1'b0;
    result_valid_d = 1'b0;
    ov_any_d       = 1'b0;
    err_d          = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = start_i && (k_len_i == '0);
      end
      FEED: begin
        pe_start_d = 1'b1;
        busy_d     = 1'b1;
        lane_en_d  = skew_en;
        lane_idx_d = skew_idx;
      end
      DRAIN: begin
        pe_start_d = 1'b1;
        busy_d     = 1'b1;
      end
      HOLD: begin
        if (!result_ack_i) begin
          pe_start_d     = 1'b1;
          busy_d         = 1'b1;
          result_valid_d = 1'b1;
          ov_any_d       = result_valid_o ? ov_any_o : |ov_flags_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pe_start_o     <= 1'b0;
      lane_en_o      <= '0;
      lane_idx_o     <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      ov_any_o       <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      pe_start_o     <= pe_start_d;
      lane_en_o      <= lane_en_d;
      lane_idx_o     <= lane_idx_d;
      busy_o         <= busy_d;
      result_valid_o <= result_valid_d;
      ov_any_o       <= ov_any_d;
      err_o          <= err_d;
    end
  end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule
